// File: rtl/exception_unit.sv
// Exception/ERET sequencer: picks the highest-priority pipeline exception, reports it to CP0,
// flushes the pipeline for FLUSH_CYCLES cycles, then redirects fetch for one cycle.
module exception_unit #(
  parameter int unsigned FLUSH_CYCLES   = 3,
  parameter logic [31:0] HANDLER_VECTOR = 32'h8000_0180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_adel,
  input  logic [31:0] if_pc,
  input  logic        id_ri,
  input  logic        id_sys,
  input  logic        id_brk,
  input  logic [31:0] id_pc,
  input  logic        ex_ov,
  input  logic [31:0] ex_pc,
  input  logic        mem_ade,
  input  logic [31:0] mem_pc,
  input  logic        int_req,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [34:0] exception_bus,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {StIdle, StFlush, StRedirect} state_e;

  localparam logic [2:0] CodeInt    = 3'd1;
  localparam logic [2:0] CodeAdelIf = 3'd2;
  localparam logic [2:0] CodeRi     = 3'd3;
  localparam logic [2:0] CodeOv     = 3'd4;
  localparam logic [2:0] CodeSys    = 3'd5;
  localparam logic [2:0] CodeBrk    = 3'd6;
  localparam logic [2:0] CodeAdeMem = 3'd7;

  // Counter holds the number of flush cycles still to follow the current one.
  localparam logic [3:0] CountLoad = 4'(FLUSH_CYCLES - 1);

  state_e      state_q;
  logic [3:0]  count_q;
  logic [31:0] target_q;

  logic [2:0]  req_code;
  logic [31:0] req_pc;
  logic        int_ok;

  assign int_ok = int_req & status_ie & ~status_exl;

  always_comb begin
    req_code = 3'd0;
    req_pc   = 32'd0;
    if (mem_ade) begin
      req_code = CodeAdeMem;
      req_pc   = mem_pc;
    end else if (ex_ov) begin
      req_code = CodeOv;
      req_pc   = ex_pc;
    end else if (id_ri) begin
      req_code = CodeRi;
      req_pc   = id_pc;
    end else if (id_sys) begin
      req_code = CodeSys;
      req_pc   = id_pc;
    end else if (id_brk) begin
      req_code = CodeBrk;
      req_pc   = id_pc;
    end else if (if_adel) begin
      req_code = CodeAdelIf;
      req_pc   = if_pc;
    end else if (int_ok) begin
      req_code = CodeInt;
      req_pc   = mem_pc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      count_q        <= 4'd0;
      target_q       <= 32'd0;
      exception_bus  <= 35'd0;
      flush          <= 1'b0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'd0;
    end else begin
      case (state_q)
        StIdle: begin
          // An exception wins over a simultaneous eret.
          if (req_code != 3'd0) begin
            state_q       <= StFlush;
            count_q       <= CountLoad;
            target_q      <= HANDLER_VECTOR;
            exception_bus <= {req_code, req_pc};
            flush         <= 1'b1;
            busy          <= 1'b1;
          end else if (eret) begin
            state_q  <= StFlush;
            count_q  <= CountLoad;
            target_q <= epc;
            flush    <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StFlush: begin
          exception_bus <= 35'd0;
          if (count_q == 4'd0) begin
            state_q        <= StRedirect;
            flush          <= 1'b0;
            redirect_valid <= 1'b1;
            redirect_pc    <= target_q;
          end else begin
            count_q <= count_q - 4'd1;
          end
        end
        StRedirect: begin
          state_q        <= StIdle;
          busy           <= 1'b0;
          redirect_valid <= 1'b0;
          redirect_pc    <= 32'd0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// Bench for exception_unit: directed scenarios plus random traffic against a cycle-offset model.
module tb_exception_unit;

  localparam int          F  = 3;
  localparam logic [31:0] HV = 32'h8000_0180;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_adel, id_ri, id_sys, id_brk, ex_ov, mem_ade;
  logic        int_req, status_ie, status_exl, eret;
  logic [31:0] if_pc, id_pc, ex_pc, mem_pc, epc;

  logic [34:0] exception_bus, exception_bus1;
  logic        flush, busy, redirect_valid;
  logic        flush1, busy1, redirect_valid1;
  logic [31:0] redirect_pc, redirect_pc1;
  logic [69:0] obs, obs1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: a sequence accepted at edge m_start shapes the outputs purely by edge offset.
  bit          m_active = 1'b0;
  int          m_start = 0;
  logic [2:0]  m_code;
  logic [31:0] m_pc, m_target;

  assign obs  = {exception_bus, flush, busy, redirect_valid, redirect_pc};
  assign obs1 = {exception_bus1, flush1, busy1, redirect_valid1, redirect_pc1};

  always #5 clk = ~clk;

  exception_unit #(.FLUSH_CYCLES(F), .HANDLER_VECTOR(HV)) dut (
    .clk(clk), .reset(reset), .if_adel(if_adel), .if_pc(if_pc), .id_ri(id_ri),
    .id_sys(id_sys), .id_brk(id_brk), .id_pc(id_pc), .ex_ov(ex_ov), .ex_pc(ex_pc),
    .mem_ade(mem_ade), .mem_pc(mem_pc), .int_req(int_req), .status_ie(status_ie),
    .status_exl(status_exl), .eret(eret), .epc(epc), .exception_bus(exception_bus),
    .flush(flush), .busy(busy), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  exception_unit #(.FLUSH_CYCLES(1), .HANDLER_VECTOR(HV)) dut1 (
    .clk(clk), .reset(reset), .if_adel(if_adel), .if_pc(if_pc), .id_ri(id_ri),
    .id_sys(id_sys), .id_brk(id_brk), .id_pc(id_pc), .ex_ov(ex_ov), .ex_pc(ex_pc),
    .mem_ade(mem_ade), .mem_pc(mem_pc), .int_req(int_req), .status_ie(status_ie),
    .status_exl(status_exl), .eret(eret), .epc(epc), .exception_bus(exception_bus1),
    .flush(flush1), .busy(busy1), .redirect_valid(redirect_valid1),
    .redirect_pc(redirect_pc1)
  );

  task automatic clear_inputs();
    {if_adel, id_ri, id_sys, id_brk, ex_ov, mem_ade} = '0;
    {int_req, status_ie, status_exl, eret} = '0;
    if_pc  = $urandom;
    id_pc  = $urandom;
    ex_pc  = $urandom;
    mem_pc = $urandom;
    epc    = $urandom;
  endtask

  task automatic random_inputs();
    if_adel    = ($urandom_range(0, 9) == 0);
    id_ri      = ($urandom_range(0, 9) == 0);
    id_sys     = ($urandom_range(0, 9) == 0);
    id_brk     = ($urandom_range(0, 9) == 0);
    ex_ov      = ($urandom_range(0, 9) == 0);
    mem_ade    = ($urandom_range(0, 9) == 0);
    int_req    = ($urandom_range(0, 3) == 0);
    status_ie  = 1'($urandom);
    status_exl = 1'($urandom);
    eret       = ($urandom_range(0, 7) == 0);
    if_pc  = $urandom;
    id_pc  = $urandom;
    ex_pc  = $urandom;
    mem_pc = $urandom;
    epc    = $urandom;
  endtask

  // Decide what the edge about to happen does, from the inputs currently applied.
  task automatic model_edge();
    if (!reset) begin
      m_active = 1'b0;
      return;
    end
    if (m_active && (cyc - m_start) < F + 2) return;
    m_active = 1'b1;
    m_start  = cyc;
    m_target = HV;
    if (mem_ade) begin
      m_code = 3'd7; m_pc = mem_pc;
    end else if (ex_ov) begin
      m_code = 3'd4; m_pc = ex_pc;
    end else if (id_ri) begin
      m_code = 3'd3; m_pc = id_pc;
    end else if (id_sys) begin
      m_code = 3'd5; m_pc = id_pc;
    end else if (id_brk) begin
      m_code = 3'd6; m_pc = id_pc;
    end else if (if_adel) begin
      m_code = 3'd2; m_pc = if_pc;
    end else if (int_req && status_ie && !status_exl) begin
      m_code = 3'd1; m_pc = mem_pc;
    end else if (eret) begin
      m_code = 3'd0; m_pc = 32'd0; m_target = epc;
    end else begin
      m_active = 1'b0;
    end
  endtask

  function automatic logic [69:0] exp_out();
    int          d;
    logic [34:0] eb;
    logic        fl, bs, rv;
    logic [31:0] rp;
    d  = cyc - m_start;
    eb = '0;
    fl = 1'b0;
    bs = 1'b0;
    rv = 1'b0;
    rp = '0;
    if (m_active && d >= 0 && d <= F) begin
      bs = 1'b1;
      fl = (d < F);
      rv = (d == F);
      if (rv) rp = m_target;
      if (d == 0) eb = {m_code, m_pc};
    end
    return {eb, fl, bs, rv, rp};
  endfunction

  task automatic tick();
    cyc++;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (obs !== 70'd0 || obs1 !== 70'd0) begin
      errors++;
      $display("FAIL reset_initial got=%h/%h expected=0", obs, obs1);
    end
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      id_ri = 1'b1;
      tick();
      checks++;
      if (obs !== 70'd0) begin
        errors++;
        $display("FAIL reset_held cyc=%0d got=%h expected=0", cyc, obs);
      end
    end
    clear_inputs();
    reset  = 1'b1;
    id_sys = 1'b1;
    tick();
    checks++;
    if (exception_bus !== {3'd5, id_pc} || obs !== exp_out()) begin
      errors++;
      $display("FAIL reset_first_edge got=%h expected=%h", obs, exp_out());
    end
    clear_inputs();
    for (int i = 0; i < F + 2; i++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL reset_drain cyc=%0d got=%h expected=%h", cyc, obs, exp_out());
      end
    end
  endtask

  task automatic test_overflow();
    clear_inputs();
    ex_ov = 1'b1;
    ex_pc = 32'h0040_0010;
    tick();
    checks++;
    if (exception_bus !== 35'h4_0040_0010 || flush !== 1'b1) begin
      errors++;
      $display("FAIL ov_report got=%h flush=%b expected=400400010 flush=1", exception_bus, flush);
    end
    clear_inputs();
    for (int i = 1; i <= 4; i++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL ov_seq step=%0d got=%h expected=%h", i, obs, exp_out());
      end
      if (i == 3) begin
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h8000_0180 || flush !== 1'b0) begin
          errors++;
          $display("FAIL ov_redirect got rv=%b pc=%h fl=%b expected rv=1 pc=80000180 fl=0",
                   redirect_valid, redirect_pc, flush);
        end
      end
      if (i == 4) begin
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL ov_idle got busy=%b expected 0", busy);
        end
      end
    end
  endtask

  task automatic test_priority();
    int reports;
    reports = 0;
    clear_inputs();
    mem_ade = 1'b1;
    ex_ov   = 1'b1;
    id_sys  = 1'b1;
    mem_pc  = 32'h0040_0020;
    // Held through FLUSH and REDIRECT, dropped before the next accepting edge.
    for (int i = 0; i <= F + 1; i++) begin
      tick();
      if (exception_bus !== 35'd0) reports++;
      if (i == 0) begin
        checks++;
        if (exception_bus !== {3'd7, 32'h0040_0020}) begin
          errors++;
          $display("FAIL prio_code got=%h expected=%h", exception_bus, {3'd7, 32'h0040_0020});
        end
      end
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL prio_seq step=%0d got=%h expected=%h", i, obs, exp_out());
      end
    end
    clear_inputs();
    tick();
    checks++;
    if (reports != 1 || obs !== 70'd0) begin
      errors++;
      $display("FAIL prio_once got reports=%0d obs=%h expected reports=1 obs=0", reports, obs);
    end
  endtask

  task automatic test_int_mask();
    clear_inputs();
    int_req    = 1'b1;
    status_ie  = 1'b1;
    status_exl = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (obs !== 70'd0 || obs !== exp_out()) begin
        errors++;
        $display("FAIL int_masked cyc=%0d got=%h expected=0", cyc, obs);
      end
    end
    status_exl = 1'b0;
    tick();
    checks++;
    if (exception_bus !== {3'd1, mem_pc} || obs !== exp_out()) begin
      errors++;
      $display("FAIL int_taken got=%h expected=%h", exception_bus, {3'd1, mem_pc});
    end
    clear_inputs();
    for (int i = 0; i < F + 2; i++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL int_drain cyc=%0d got=%h expected=%h", cyc, obs, exp_out());
      end
    end
  endtask

  task automatic test_eret();
    int flushes;
    flushes = 0;
    clear_inputs();
    eret = 1'b1;
    epc  = 32'h0040_0100;
    for (int i = 0; i <= F + 1; i++) begin
      tick();
      if (i == 0) clear_inputs();
      if (flush === 1'b1) flushes++;
      checks++;
      if (exception_bus !== 35'd0 || obs !== exp_out()) begin
        errors++;
        $display("FAIL eret_seq step=%0d got=%h expected=%h", i, obs, exp_out());
      end
      if (i == F) begin
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0100) begin
          errors++;
          $display("FAIL eret_target got rv=%b pc=%h expected rv=1 pc=00400100",
                   redirect_valid, redirect_pc);
        end
      end
    end
    checks++;
    if (flushes != 3) begin
      errors++;
      $display("FAIL eret_flush_len got=%0d expected=3", flushes);
    end
    clear_inputs();
    eret   = 1'b1;
    epc    = 32'h0040_0100;
    id_brk = 1'b1;
    for (int i = 0; i <= F + 1; i++) begin
      tick();
      if (i == 0) begin
        clear_inputs();
        checks++;
        if (exception_bus[34:32] !== 3'd6) begin
          errors++;
          $display("FAIL eret_brk_code got=%0d expected=6", exception_bus[34:32]);
        end
      end
      if (i == F) begin
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== HV) begin
          errors++;
          $display("FAIL eret_brk_target got rv=%b pc=%h expected rv=1 pc=%h",
                   redirect_valid, redirect_pc, HV);
        end
      end
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL eret_brk_seq step=%0d got=%h expected=%h", i, obs, exp_out());
      end
    end
  endtask

  task automatic test_reset_mid_flush();
    int rv_seen;
    rv_seen = 0;
    clear_inputs();
    id_ri = 1'b1;
    tick();
    clear_inputs();
    tick();
    #2;
    reset    = 1'b0;
    m_active = 1'b0;
    #1;
    checks++;
    if (obs !== 70'd0) begin
      errors++;
      $display("FAIL abort_async got=%h expected=0", obs);
    end
    for (int i = 0; i < 2; i++) tick();
    reset = 1'b1;
    for (int i = 0; i < F + 2; i++) begin
      tick();
      if (redirect_valid === 1'b1) rv_seen++;
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL abort_after cyc=%0d got=%h expected=%h", cyc, obs, exp_out());
      end
    end
    checks++;
    if (rv_seen != 0) begin
      errors++;
      $display("FAIL abort_no_redirect got=%0d pulses expected=0", rv_seen);
    end
  endtask

  task automatic test_back_to_back();
    logic [69:0] e1;
    int          k3;
    clear_inputs();
    #2;
    reset    = 1'b0;
    m_active = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    id_ri = 1'b1;
    id_pc = 32'h0040_0200;
    for (int k = 0; k < 9; k++) begin
      tick();
      k3 = k % 3;
      e1 = '0;
      if (k3 == 0) e1 = {3'd3, 32'h0040_0200, 1'b1, 1'b1, 1'b0, 32'd0};
      if (k3 == 1) e1 = {35'd0, 1'b0, 1'b1, 1'b1, HV};
      checks++;
      if (obs1 !== e1) begin
        errors++;
        $display("FAIL b2b_f1 k=%0d got=%h expected=%h", k, obs1, e1);
      end
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL b2b_f3 k=%0d got=%h expected=%h", k, obs, exp_out());
      end
    end
    clear_inputs();
    for (int i = 0; i < F + 2; i++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL b2b_drain cyc=%0d got=%h expected=%h", cyc, obs, exp_out());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      random_inputs();
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h expected=%h", cyc, obs, exp_out());
      end
    end
    clear_inputs();
    for (int i = 0; i < F + 2; i++) begin
      tick();
      checks++;
      if (obs !== exp_out()) begin
        errors++;
        $display("FAIL random_drain cyc=%0d got=%h expected=%h", cyc, obs, exp_out());
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_overflow();
    test_priority();
    test_int_mask();
    test_eret();
    test_reset_mid_flush();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 The block SHALL provide parameter FLUSH_CYCLES, default 3, which sets the number of pipeline flush cycles; its legal range SHALL be 1..15.
REQ-002 The block SHALL provide parameter HANDLER_VECTOR, default 32'h8000_0180, which is the exception handler entry PC.
REQ-003 The block SHALL provide clk  in  1  system clock, with all state updating on the rising edge.
REQ-004 The block SHALL provide reset  in  1  reset, asynchronous and active-low (asserted when 0).
REQ-005 The block SHALL provide if_adel  in  1  fetch address error, and if_pc  in  32  fetch-stage PC.
REQ-006 The block SHALL provide id_ri, id_sys, id_brk  in  1 each  reserved-instruction, syscall and break requests, and id_pc  in  32  decode-stage PC.
REQ-007 The block SHALL provide ex_ov  in  1  arithmetic overflow, and ex_pc  in  32  execute-stage PC.
REQ-008 The block SHALL provide mem_ade  in  1  data address error, and mem_pc  in  32  memory-stage PC.
REQ-009 The block SHALL provide int_req  in  1  external interrupt request (level).
REQ-010 The block SHALL provide status_ie and status_exl  in  1 each  copies of the SR interrupt-enable and exception-level bits from coprocessor 0.
REQ-011 The block SHALL provide eret  in  1  exception-return request, and epc  in  32  EPC value read from coprocessor 0.
REQ-012 The block SHALL provide exception_bus  out  35  registered coprocessor-0 report: [34:32] cause code and [31:0] faulting PC; a code of 0 means no exception.
REQ-013 The block SHALL provide flush  out  1  a kill of all in-flight pipeline stages.
REQ-014 The block SHALL provide busy  out  1  high in every state except IDLE.
REQ-015 The block SHALL provide redirect_valid  out  1  and redirect_pc  out  32  a one-cycle PC override toward fetch.

Function
REQ-016 Cause codes SHALL be: 1 INT, 2 ADEL_IF, 3 RI, 4 OV, 5 SYS, 6 BRK, 7 ADE_MEM.
REQ-017 Priority, highest first, SHALL be: mem_ade > ex_ov > id_ri > id_sys > id_brk > if_adel > interrupt; only the winner is reported.
REQ-018 The reported PC SHALL be the PC of the winning request's stage; an interrupt SHALL report mem_pc.
REQ-019 An interrupt SHALL be eligible only when int_req=1, status_ie=1 and status_exl=0; synchronous causes SHALL be taken regardless of status bits.
REQ-020 The FSM SHALL have three states: IDLE, FLUSH and REDIRECT.
REQ-021 IDLE with any eligible request at edge T: code and PC latched, state becomes FLUSH, target = HANDLER_VECTOR.
REQ-022 IDLE with no request and eret=1 at edge T: state becomes FLUSH, target = epc, exception_bus stays 0.
REQ-023 A simultaneous exception and eret SHALL be resolved in favour of the exception; the eret is dropped.
REQ-024 exception_bus SHALL carry the latched {code, PC} for exactly the first FLUSH cycle (T+1) and SHALL be 0 in all other cycles.
REQ-025 flush SHALL be high for exactly FLUSH_CYCLES consecutive cycles (T+1 .. T+FLUSH_CYCLES), timed by a down-counter loaded on entry to FLUSH.
REQ-026 While in FLUSH, all inputs SHALL be ignored.
REQ-027 When the counter expires, the FSM SHALL enter REDIRECT for one cycle (T+FLUSH_CYCLES+1) with redirect_valid=1, redirect_pc=target and flush=0.
REQ-028 After REDIRECT the FSM SHALL return to IDLE; a new request SHALL be accepted on the first IDLE edge, so the minimum spacing between reports is FLUSH_CYCLES+2 cycles.
REQ-029 redirect_pc SHALL be 0 whenever redirect_valid=0.
REQ-030 While in REDIRECT, requests SHALL be ignored; they are expected to be reasserted by the pipeline.

Reset
REQ-031 While reset=0, regardless of clk: state=IDLE, counter=0, target=0, exception_bus=0, flush=0, busy=0, redirect_valid=0, redirect_pc=0.
REQ-032 A reset asserted mid-FLUSH or mid-REDIRECT SHALL abort the sequence with no redirect issued.
REQ-033 After reset deassertion, the first rising edge SHALL already evaluate requests.

Verification
REQ-034 Overflow: ex_ov=1, ex_pc=32'h0040_0010 at T -> exception_bus=35'h4_0040_0010 at T+1 only; flush high T+1..T+3; redirect_valid=1, redirect_pc=32'h8000_0180 at T+4; busy=0 at T+5.
REQ-035 Priority: mem_ade, ex_ov and id_sys together, mem_pc=32'h0040_0020 -> code 7, PC 32'h0040_0020, exactly one report.
REQ-036 Interrupt masking: int_req=1 with status_exl=1 -> no activity for 10 cycles; then status_exl=0 with status_ie=1 -> code 1 with PC = mem_pc.
REQ-037 ERET: eret=1, epc=32'h0040_0100, no exception -> exception_bus stays 0; flush 3 cycles; redirect_pc=32'h0040_0100; eret together with id_brk -> code 6 and handler redirect.
REQ-038 Reset at second FLUSH cycle -> all outputs 0 immediately (asynchronously); no redirect_valid pulse observed.
REQ-039 Back-to-back: id_ri held high continuously with FLUSH_CYCLES=1 -> reports at T+1, T+4, T+7; request ignored during busy.
